uart_tx_sequencer: RTL and testbench

- Streams byte strings from a shared text buffer into the byte-wide UART transmitter, one byte per UART frame.
- Arbitrates two requesters for the single TX path:
  - requester 0: board redraw;
  - requester 1: status/score line.
- Replaces the single-shot wide-blob strobe. The game top issues (base, length) jobs, and this block fetches bytes, paces them against tx busy, and reports completion.

---
 rtl/uart_tx_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: streams (base, length) byte jobs from a shared text buffer
// into a byte-wide UART transmitter. Two requesters are served round-robin:
// bit 0 is the board redraw and bit 1 is the status/score line.
//
// Optional build macro UART_TX_SEQ_CRLF_EN: after every transmitted 8'h0A the
// sequencer sends an extra 8'h0D. The buffer therefore only needs to hold
// bare line feeds. When the macro is undefined, bytes pass through unchanged.
//
// All outputs are registered. The memory read strobe, grant, done and active
// flags are loaded on the edge that enters the matching state, so each one is
// visible for the whole cycle that the state occupies. The transmit strobe is
// raised on the edge where SEND sees the UART idle. The UART therefore sees it
// during GAP, and busy is already up by the time WAIT_TX samples it.
module uart_tx_sequencer #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_req,
    input  logic [ADDR_W-1:0] i_base0,
    input  logic [LEN_W-1:0]  i_len0,
    input  logic [ADDR_W-1:0] i_base1,
    input  logic [LEN_W-1:0]  i_len1,
    output logic [1:0]        o_grant,
    output logic [1:0]        o_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_stb,
    input  logic              i_tx_busy,
    output logic              o_active
);

`ifdef UART_TX_SEQ_CRLF_EN
    localparam logic CRLF_EN = 1'b1;
`else
    localparam logic CRLF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_SEND      = 3'd3,
        S_GAP       = 3'd4,
        S_WAIT_TX   = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_grant;
    logic [1:0]        r_done;
    logic              r_active;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_stb;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_rr_ptr;     // requester favoured on a tie
    logic              r_crlf_pend;  // last buffer byte was LF, CR still owed
    logic              r_inject;     // byte in SEND is the injected CR

    logic              w_sel;
    logic [1:0]        w_sel_onehot;
    logic [ADDR_W-1:0] w_sel_base;
    logic [LEN_W-1:0]  w_sel_len;
    logic [ADDR_W-1:0] w_fetch_addr;

    // Pick the requester to grant from IDLE and mux its job descriptor.
    always_comb begin
        w_sel = 1'b0;
        case (i_req)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = r_rr_ptr;
            default: w_sel = 1'b0;
        endcase
        w_sel_onehot = w_sel ? 2'b10 : 2'b01;
        w_sel_base   = w_sel ? i_base1 : i_base0;
        w_sel_len    = w_sel ? i_len1 : i_len0;
        // On the grant edge cur_addr is not loaded yet, so read the base directly.
        w_fetch_addr = (r_state == S_IDLE) ? w_sel_base : r_cur_addr;
    end

    // Next-state decode for the job sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req != 2'b00) begin
                    if (w_sel_len == {LEN_W{1'b0}}) begin
                        w_next = S_FINISH;
                    end else begin
                        w_next = S_FETCH;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH:     w_next = S_WAIT_DATA;
            S_WAIT_DATA: w_next = S_SEND;
            S_SEND: begin
                if (!i_tx_busy) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_SEND;
                end
            end
            S_GAP:       w_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (i_tx_busy) begin
                    w_next = S_WAIT_TX;
                end else if (r_crlf_pend) begin
                    w_next = S_SEND;
                end else if (r_remaining != {LEN_W{1'b0}}) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant     <= 2'b00;
            r_done      <= 2'b00;
            r_active    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_tx_data   <= 8'h00;
            r_tx_stb    <= 1'b0;
            r_cur_addr  <= {ADDR_W{1'b0}};
            r_remaining <= {LEN_W{1'b0}};
            r_rr_ptr    <= 1'b0;
            r_crlf_pend <= 1'b0;
            r_inject    <= 1'b0;
        end else begin
            r_mem_rd <= (w_next == S_FETCH);
            if (w_next == S_FETCH) begin
                r_mem_addr <= w_fetch_addr;
            end
            r_tx_stb <= 1'b0;
            r_done   <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (i_req != 2'b00) begin
                        r_grant     <= w_sel_onehot;
                        r_active    <= 1'b1;
                        r_cur_addr  <= w_sel_base;
                        r_remaining <= w_sel_len;
                        r_rr_ptr    <= ~w_sel;
                        r_crlf_pend <= 1'b0;
                        r_inject    <= 1'b0;
                        if (w_sel_len == {LEN_W{1'b0}}) begin
                            r_done <= w_sel_onehot;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    r_tx_data <= i_mem_data;
                end
                S_SEND: begin
                    if (!i_tx_busy) begin
                        r_tx_stb <= 1'b1;
                        if (r_inject) begin
                            r_inject <= 1'b0;
                        end else begin
                            r_cur_addr  <= r_cur_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                            r_remaining <= r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
                            r_crlf_pend <= CRLF_EN && (r_tx_data == 8'h0A);
                        end
                    end
                end
                S_WAIT_TX: begin
                    if (!i_tx_busy) begin
                        if (r_crlf_pend) begin
                            r_tx_data   <= 8'h0D;
                            r_inject    <= 1'b1;
                            r_crlf_pend <= 1'b0;
                        end else if (r_remaining == {LEN_W{1'b0}}) begin
                            r_done <= r_grant;
                        end
                    end
                end
                S_FINISH: begin
                    r_grant  <= 2'b00;
                    r_active <= 1'b0;
                end
                default: begin
                    r_tx_stb <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant    = r_grant;
    assign o_done     = r_done;
    assign o_active   = r_active;
    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_tx_data  = r_tx_data;
    assign o_tx_stb   = r_tx_stb;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a registered-read buffer model and
// a UART model that stays busy for busy_len cycles after each strobe.
module tb_uart_tx_sequencer;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        i_req;
    logic [ADDR_W-1:0] i_base0, i_base1;
    logic [LEN_W-1:0]  i_len0, i_len1;
    logic [1:0]        o_grant, o_done;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd;
    logic [7:0]        i_mem_data = 8'h00;
    logic [7:0]        o_tx_data;
    logic              o_tx_stb;
    logic              i_tx_busy;
    logic              o_active;

    uart_tx_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .i_req(i_req),
        .i_base0(i_base0), .i_len0(i_len0), .i_base1(i_base1), .i_len1(i_len1),
        .o_grant(o_grant), .o_done(o_done), .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
        .i_mem_data(i_mem_data), .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb),
        .i_tx_busy(i_tx_busy), .o_active(o_active)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    int         busy_len   = 20;
    int         busy_cnt   = 0;
    logic       force_busy = 1'b0;
    assign i_tx_busy = (busy_cnt != 0) || force_busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_q[$];
    logic [9:0] addr_q[$];
    logic [7:0] ev_q[$];
    int         done_cnt = 0, rd_cnt = 0, stb_busy_err = 0;
    int         cyc = 0, grant_cyc = 0, done_cyc = 0;
    logic [1:0] prev_grant = 2'b00, last_done = 2'b00;

    // Buffer model, UART model and event logger.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (o_mem_rd) begin
            i_mem_data <= mem[o_mem_addr];
            addr_q.push_back(o_mem_addr);
            rd_cnt = rd_cnt + 1;
        end
        if (o_tx_stb) begin
            tx_q.push_back(o_tx_data);
            if (i_tx_busy) stb_busy_err = stb_busy_err + 1;
            busy_cnt = busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
        end
        if (prev_grant == 2'b00 && o_grant != 2'b00) begin
            ev_q.push_back({6'h04, o_grant});
            grant_cyc = cyc;
        end
        prev_grant = o_grant;
        if (o_done != 2'b00) begin
            ev_q.push_back({6'h08, o_done});
            done_cnt  = done_cnt + 1;
            last_done = o_done;
            done_cyc  = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_q.size()) ? {22'h0, addr_q[i]} : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] ev_at(input int i);
        return (i < ev_q.size()) ? {24'h0, ev_q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        tx_q.delete(); addr_q.delete(); ev_q.delete();
        done_cnt = 0; rd_cnt = 0; stb_busy_err = 0; last_done = 2'b00;
    endtask

    task automatic wait_done(input int n, input int max_cyc, input string tag);
        int k = 0;
        while (done_cnt < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < n) check_eq(tag, done_cnt, n);
    endtask

    task automatic wait_grant(input string tag);
        int k = 0;
        while (o_grant == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (o_grant == 2'b00) check_eq(tag, {30'h0, o_grant}, 32'h1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant"}, o_grant, 2'b00);
        check_eq({tag, "_done"}, o_done, 2'b00);
        check_eq({tag, "_active"}, o_active, 1'b0);
        check_eq({tag, "_mem_rd"}, o_mem_rd, 1'b0);
        check_eq({tag, "_mem_addr"}, o_mem_addr, 10'h000);
        check_eq({tag, "_tx_stb"}, o_tx_stb, 1'b0);
        check_eq({tag, "_tx_data"}, o_tx_data, 8'h00);
    endtask

    initial begin
        logic [7:0] exp_ev [8];
        logic [7:0] exp_tx [8];
        int         n_crlf;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst = 1'b0; i_req = 2'b00;
        i_base0 = 10'h000; i_len0 = 10'd0; i_base1 = 10'h000; i_len1 = 10'd0;
        step(3);
        check_idle_outputs("reset");
        rst = 1'b1;
        step(2);
        check_eq("post_reset_active", o_active, 1'b0);

        // Arbitration: both held, grants alternate starting with requester 0.
        mem[10'h100] = 8'h61; mem[10'h101] = 8'h62;
        mem[10'h180] = 8'h63; mem[10'h181] = 8'h64;
        i_base0 = 10'h100; i_len0 = 10'd2; i_base1 = 10'h180; i_len1 = 10'd2;
        busy_len = 3;
        clear_logs();
        i_req = 2'b11;
        wait_done(4, 1000, "arb_timeout");
        i_req = 2'b00;
        step(5);
        exp_ev = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h11, 8'h21, 8'h12, 8'h22};
        exp_tx = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h61, 8'h62, 8'h63, 8'h64};
        check_eq("arb_ev_count", ev_q.size(), 8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("arb_ev%0d", i), ev_at(i), {24'h0, exp_ev[i]});
        check_eq("arb_tx_count", tx_q.size(), 8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("arb_tx%0d", i), tx_at(i), {24'h0, exp_tx[i]});

        // Zero length on requester 1: no reads, no strobes, quick done.
        clear_logs();
        i_base1 = 10'h155; i_len1 = 10'd0;
        i_req = 2'b10;
        wait_done(1, 20, "zero_timeout");
        i_req = 2'b00;
        step(3);
        check_eq("zero_rd_count", rd_cnt, 0);
        check_eq("zero_tx_count", tx_q.size(), 0);
        check_eq("zero_done_val", last_done, 2'b10);
        check_eq("zero_done_cnt", done_cnt, 1);
        check_eq("zero_done_latency", (done_cyc - grant_cyc) <= 3, 1'b1);

        // Wrap and busy stall.
        mem[10'h3FF] = 8'h11; mem[10'h000] = 8'h22;
        busy_len = 20;
        force_busy = 1'b1;
        clear_logs();
        i_base0 = 10'h3FF; i_len0 = 10'd2;
        i_req = 2'b01;
        wait_grant("wrap_grant_timeout");
        i_req = 2'b00;
        step(50);
        check_eq("wrap_stall_tx_count", tx_q.size(), 0);
        check_eq("wrap_stall_active", o_active, 1'b1);
        force_busy = 1'b0;
        wait_done(1, 500, "wrap_timeout");
        step(2);
        check_eq("wrap_addr0", addr_at(0), 32'h3FF);
        check_eq("wrap_addr1", addr_at(1), 32'h000);
        check_eq("wrap_tx0", tx_at(0), 32'h11);
        check_eq("wrap_tx1", tx_at(1), 32'h22);
        check_eq("wrap_stb_busy", stb_busy_err, 0);
        check_eq("wrap_done_val", last_done, 2'b01);

        // Single job "ABC" at 0x010; descriptor changes after grant are ignored.
        mem[10'h010] = 8'h41; mem[10'h011] = 8'h42; mem[10'h012] = 8'h43;
        clear_logs();
        i_base0 = 10'h010; i_len0 = 10'd3;
        i_req = 2'b01;
        wait_grant("single_grant_timeout");
        i_req = 2'b00; i_base0 = 10'h200; i_len0 = 10'd7;
        step(3);
        check_eq("single_grant_held", o_grant, 2'b01);
        check_eq("single_active_held", o_active, 1'b1);
        wait_done(1, 500, "single_timeout");
        step(3);
        check_eq("single_tx_count", tx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("single_tx%0d", i), tx_at(i), 32'h41 + i);
            check_eq($sformatf("single_addr%0d", i), addr_at(i), 32'h010 + i);
        end
        check_eq("single_done_cnt", done_cnt, 1);
        check_eq("single_done_val", last_done, 2'b01);
        check_eq("single_stb_busy", stb_busy_err, 0);
        check_eq("single_end_active", o_active, 1'b0);
        check_eq("single_end_grant", o_grant, 2'b00);

        // Line feed handling.
        mem[10'h020] = 8'h58; mem[10'h021] = 8'h0A; mem[10'h022] = 8'h59;
        busy_len = 5;
        clear_logs();
        i_base0 = 10'h020; i_len0 = 10'd3;
        i_req = 2'b01;
        wait_grant("crlf_grant_timeout");
        i_req = 2'b00;
        wait_done(1, 500, "crlf_timeout");
        step(3);
`ifdef UART_TX_SEQ_CRLF_EN
        exp_tx = '{8'h58, 8'h0A, 8'h0D, 8'h59, 8'h00, 8'h00, 8'h00, 8'h00};
        n_crlf = 4;
`else
        exp_tx = '{8'h58, 8'h0A, 8'h59, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n_crlf = 3;
`endif
        check_eq("crlf_tx_count", tx_q.size(), n_crlf);
        for (int i = 0; i < n_crlf; i++) check_eq($sformatf("crlf_tx%0d", i), tx_at(i), {24'h0, exp_tx[i]});
        check_eq("crlf_rd_count", rd_cnt, 3);
        check_eq("crlf_addr2", addr_at(2), 32'h022);
        check_eq("crlf_done_cnt", done_cnt, 1);

        // Reset in the middle of a job.
        busy_len = 20;
        clear_logs();
        i_base0 = 10'h010; i_len0 = 10'd3;
        i_req = 2'b01;
        wait_grant("midrst_grant_timeout");
        i_req = 2'b00;
        for (int k = 0; k < 100 && tx_q.size() == 0; k++) @(negedge clk);
        check_eq("midrst_first_stb", tx_q.size(), 1);
        check_eq("midrst_active_before", o_active, 1'b1);
        rst = 1'b0;
        step(3);
        check_idle_outputs("midrst");
        rst = 1'b1;
        step(3);
        check_eq("midrst_after_active", o_active, 1'b0);
        check_eq("midrst_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
